// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared stall-vector layout, stall encodings and multi-cycle FSM states for pipe_ctrl.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

   // Register address width used across the core's register-file buses.
   localparam int RegAddrBus = 5;

   // Stall vector layout: one hold bit per pipeline register, PC first.
   localparam int STALL_W   = 6;
   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   // Stall encodings. Holding everything up to stage N means the register
   // just after N takes a bubble.
   localparam logic [STALL_W-1:0] StallNone   = 6'b000000;
   localparam logic [STALL_W-1:0] StallFromId = 6'b000111;  // PC/IF/ID held, ID_EX bubbles
   localparam logic [STALL_W-1:0] StallFromEx = 6'b001111;  // PC/IF/ID/EX held, EX_MEM bubbles

   // Multi-cycle EX sequencer states.
   typedef enum logic [1:0] {
      MC_IDLE = 2'd0,
      MC_RUN  = 2'd1,
      MC_DONE = 2'd2
   } mc_state_t;

   // Counter width able to hold LAT-1 for the longer op; never narrower than 1 bit.
   function automatic int mc_cnt_width(input int mul_lat, input int div_lat);
      int max_lat;
      max_lat = (mul_lat > div_lat) ? mul_lat : div_lat;
      return (max_lat > 1) ? $clog2(max_lat) : 1;
   endfunction

endpackage

// File: rtl/pipe_ctrl_mc_seq.sv
// Purpose: sequences a mul/div sitting in EX; raises mc_req while EX must hold, pulses mc_done when the result is ready.
// Latency: mc_req combinational on entry; LAT+1 request cycles, then one mc_done cycle.
// Backpressure: none accepted; ex_mc_start is a level held by the pipeline while the op sits in EX.
module mc_seq
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic ex_mc_start,
   input  logic ex_mc_kind,
   output logic mc_req,
   output logic mc_busy,
   output logic mc_done
);

   localparam int CNT_W = mc_cnt_width(MUL_LAT, DIV_LAT);

   // Counter preload values: RUN lasts exactly LAT cycles (LAT-1 down to 0).
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

   mc_state_t        state_q;
   mc_state_t        state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // State and latency counter registers; synchronous reset aborts any op in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MC_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, counter update and request/busy/done decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mc_req  = 1'b0;
      mc_busy = 1'b0;
      mc_done = 1'b0;

      unique case (state_q)
         MC_IDLE: begin
            // Kind is only looked at here; it is folded into the counter preload.
            if (ex_mc_start) begin
               mc_req  = 1'b1;
               cnt_d   = ex_mc_kind ? DIV_LOAD : MUL_LOAD;
               state_d = MC_RUN;
            end
         end
         MC_RUN: begin
            mc_req  = 1'b1;
            mc_busy = 1'b1;
            if (cnt_q == '0) begin
               state_d = MC_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         MC_DONE: begin
            // The finished op is still in EX this cycle, so its start level is ignored.
            mc_done = 1'b1;
            state_d = MC_IDLE;
         end
         default: begin
            state_d = MC_IDLE;
         end
      endcase

      // Outputs are quiet while reset is held, regardless of the current state.
      if (rst) begin
         mc_req  = 1'b0;
         mc_busy = 1'b0;
         mc_done = 1'b0;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Purpose: pipeline control; merges load-use, multi-cycle EX and taken-branch events into per-stage stall and IF/ID flush.
// Latency: outputs combinational from sequencer state and current inputs.
// Backpressure: stall bits hold pipeline registers; a branch flush is suppressed while ID is held.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_LAT    = 3,
   parameter int DIV_LAT    = 32,
   parameter int REG_ADDR_W = RegAddrBus
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_re1,
   input  logic [REG_ADDR_W-1:0] id_raddr1,
   input  logic                  id_re2,
   input  logic [REG_ADDR_W-1:0] id_raddr2,
   input  logic                  ex_is_load,
   input  logic [REG_ADDR_W-1:0] ex_wd,
   input  logic                  ex_wreg,
   input  logic                  ex_mc_start,
   input  logic                  ex_mc_kind,
   input  logic                  branch_taken,
   output logic [STALL_W-1:0]    stall,
   output logic                  flush,
   output logic                  mc_busy,
   output logic                  mc_done
);

   logic mc_req;
   logic ex_load_wr;
   logic src1_hit;
   logic src2_hit;
   logic ld_req;

   mc_seq #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_mc_seq (
      .clk         (clk),
      .rst         (rst),
      .ex_mc_start (ex_mc_start),
      .ex_mc_kind  (ex_mc_kind),
      .mc_req      (mc_req),
      .mc_busy     (mc_busy),
      .mc_done     (mc_done)
   );

   // Load-use hazard: ID needs a register the load in EX has not produced yet.
   // x0 is hardwired, so a load targeting it never creates a dependency.
   always_comb begin
      ex_load_wr = ex_is_load & ex_wreg & (ex_wd != '0);
      src1_hit   = id_re1 & (id_raddr1 == ex_wd);
      src2_hit   = id_re2 & (id_raddr2 == ex_wd);
      ld_req     = ex_load_wr & (src1_hit | src2_hit);
   end

   // Stall priority (multi-cycle EX over load-use) and branch flush gated by an ID hold.
   always_comb begin
      stall = StallNone;
      flush = 1'b0;

      if (mc_req) begin
         stall = StallFromEx;
      end else if (ld_req) begin
         stall = StallFromId;
      end

      // A held ID keeps the branch in place; it re-resolves once released.
      flush = branch_taken & ~stall[STALL_ID];

      if (rst) begin
         stall = StallNone;
         flush = 1'b0;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Purpose: directed self-checking bench for pipe_ctrl with hand-computed expectations.
// Latency: inputs change 1ns after posedge, outputs sampled on negedge.
// Backpressure: n/a.
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_re1;
   logic [4:0] id_raddr1;
   logic       id_re2;
   logic [4:0] id_raddr2;
   logic       ex_is_load;
   logic [4:0] ex_wd;
   logic       ex_wreg;
   logic       ex_mc_start;
   logic       ex_mc_kind;
   logic       branch_taken;
   logic [5:0] stall;
   logic       flush;
   logic       mc_busy;
   logic       mc_done;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_ID   = 6'b000111;
   localparam logic [5:0] S_EX   = 6'b001111;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .MUL_LAT    (3),
      .DIV_LAT    (32),
      .REG_ADDR_W (5)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_re1       (id_re1),
      .id_raddr1    (id_raddr1),
      .id_re2       (id_re2),
      .id_raddr2    (id_raddr2),
      .ex_is_load   (ex_is_load),
      .ex_wd        (ex_wd),
      .ex_wreg      (ex_wreg),
      .ex_mc_start  (ex_mc_start),
      .ex_mc_kind   (ex_mc_kind),
      .branch_taken (branch_taken),
      .stall        (stall),
      .flush        (flush),
      .mc_busy      (mc_busy),
      .mc_done      (mc_done)
   );

   // Single comparison point: {stall, flush, mc_busy, mc_done}.
   task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got stall=%b flush=%b busy=%b done=%b, want stall=%b flush=%b busy=%b done=%b",
                  tag, got[8:3], got[2], got[1], got[0], exp[8:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Sample at negedge, then advance to just after the next rising edge.
   task automatic cyc(input string tag, input logic [5:0] s, input logic f, input logic b, input logic d);
      @(negedge clk);
      check(tag, {stall, flush, mc_busy, mc_done}, {s, f, b, d});
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      id_re1 = 0; id_raddr1 = 0; id_re2 = 0; id_raddr2 = 0;
      ex_is_load = 0; ex_wd = 0; ex_wreg = 0;
      ex_mc_start = 0; ex_mc_kind = 0; branch_taken = 0;
   endtask

   // Full divide with branch_taken held: stall for 33 cycles, done on the 34th.
   // Kind flips mid-op to confirm it is only sampled at issue.
   task automatic run_div(input string tag);
      ex_mc_start = 1; ex_mc_kind = 1; branch_taken = 1;
      for (int c = 1; c <= 34; c++) begin
         if (c == 5) ex_mc_kind = 0;
         if (c <= 33) cyc(tag, S_EX, 1'b0, (c >= 2), 1'b0);
         else         cyc(tag, S_NONE, 1'b1, 1'b0, 1'b1);
      end
      ex_mc_start = 0; ex_mc_kind = 0; branch_taken = 0;
      cyc({tag, "_idle"}, S_NONE, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset with every input driven high.
      rst = 1;
      id_re1 = 1; id_raddr1 = '1; id_re2 = 1; id_raddr2 = '1;
      ex_is_load = 1; ex_wd = '1; ex_wreg = 1;
      ex_mc_start = 1; ex_mc_kind = 1; branch_taken = 1;
      cyc("reset_c1", S_NONE, 0, 0, 0);
      cyc("reset_c2", S_NONE, 0, 0, 0);
      rst = 0;
      clear_inputs();
      cyc("idle", S_NONE, 0, 0, 0);

      // Load-use on source 2.
      ex_is_load = 1; ex_wreg = 1; ex_wd = 5; id_re2 = 1; id_raddr2 = 5;
      cyc("ld_use_src2", S_ID, 0, 0, 0);
      ex_wd = 0; id_raddr2 = 0;
      cyc("ld_use_x0", S_NONE, 0, 0, 0);
      // Load-use on source 1; then qualifiers removed one at a time.
      clear_inputs();
      ex_is_load = 1; ex_wreg = 1; ex_wd = 9; id_re1 = 1; id_raddr1 = 9;
      cyc("ld_use_src1", S_ID, 0, 0, 0);
      id_re1 = 0;
      cyc("ld_use_no_re", S_NONE, 0, 0, 0);
      id_re1 = 1; ex_wreg = 0;
      cyc("ld_use_no_wreg", S_NONE, 0, 0, 0);
      ex_wreg = 1; id_raddr1 = 10;
      cyc("ld_use_addr_diff", S_NONE, 0, 0, 0);
      ex_is_load = 0; id_raddr1 = 9;
      cyc("ld_use_not_load", S_NONE, 0, 0, 0);

      // Branch flush, then branch during a load-use stall.
      clear_inputs();
      branch_taken = 1;
      cyc("branch_flush", S_NONE, 1, 0, 0);
      ex_is_load = 1; ex_wreg = 1; ex_wd = 7; id_re1 = 1; id_raddr1 = 7;
      cyc("branch_in_stall", S_ID, 0, 0, 0);
      clear_inputs();

      // Divide, 33 stall cycles.
      run_div("div");

      // Two back-to-back muls: start held throughout; pattern 4 stall + 1 done, twice.
      ex_mc_start = 1; ex_mc_kind = 0;
      for (int c = 0; c < 10; c++) begin
         int k;
         k = c % 5;
         if (k < 4) cyc("mul_b2b", S_EX, 0, (k >= 1), 0);
         else       cyc("mul_b2b_done", S_NONE, 0, 0, 1);
      end
      ex_mc_start = 0;
      cyc("mul_idle", S_NONE, 0, 0, 0);

      // Multi-cycle stall outranks a simultaneous load-use.
      ex_mc_start = 1; ex_mc_kind = 0;
      ex_is_load = 1; ex_wreg = 1; ex_wd = 3; id_re2 = 1; id_raddr2 = 3;
      cyc("prio_mc_over_ld", S_EX, 0, 0, 0);
      ex_is_load = 0;
      for (int c = 0; c < 3; c++) cyc("prio_mul_run", S_EX, 0, 1, 0);
      cyc("prio_mul_done", S_NONE, 0, 0, 1);
      clear_inputs();
      cyc("prio_idle", S_NONE, 0, 0, 0);

      // Reset on cycle 10 of a divide aborts it without a done pulse.
      ex_mc_start = 1; ex_mc_kind = 1;
      for (int c = 1; c <= 9; c++) cyc("div_pre_rst", S_EX, 0, (c >= 2), 0);
      rst = 1;
      cyc("div_rst_c10", S_NONE, 0, 0, 0);
      ex_mc_start = 0;
      cyc("div_rst_c11", S_NONE, 0, 0, 0);
      rst = 0;
      cyc("after_rst_idle", S_NONE, 0, 0, 0);
      cyc("after_rst_no_done", S_NONE, 0, 0, 0);

      // Fresh divide after the abort gets the full latency.
      run_div("div_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Absolute bound on run time.
   initial begin
      #200000;
      $display("FAIL timeout: got no completion, want completion before 200000ns");
      $fatal(1);
   end

endmodule
